// File: rtl/st7920_pkg.sv
// Shared constants and types for the ST7920 serial receiver.
package st7920_pkg;

    localparam int unsigned SYNC_LEN  = 5;    // leading ones that mark a frame start
    localparam int unsigned FRAME_LEN = 24;   // bits per serial frame
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned FB_ADDR_W = 10;   // framebuffer byte address width

    // Instruction decode: function set lives in byte[7:5], GDRAM address is flagged by byte[7].
    localparam logic [2:0] OP_FUNC_SET   = 3'b001;
    localparam logic       OP_GDRAM_ADDR = 1'b1;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HDR,
        ST_HI,
        ST_PADH,
        ST_LO,
        ST_PADL
    } rx_state_e;

endpackage

// File: rtl/st7920_sclk_edge.sv
// Synchronises lcd_clk/lcd_data into sys_clk and flags lcd_clk rising edges.
//   sys_clk, sys_rst_n : block clock and async active-low reset
//   lcd_clk, lcd_data  : asynchronous serial inputs from the host
//   sclk_rise_c        : high for one cycle per synchronised lcd_clk rising edge
//   sdata              : synchronised lcd_data, valid when sclk_rise_c is high
module st7920_sclk_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic lcd_clk,
    input  logic lcd_data,
    output logic sclk_rise_c,
    output logic sdata
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;

    // Equal-length chains keep data aligned with the clock edge it belongs to.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync[0]  <= lcd_clk;
            data_sync[0] <= lcd_data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                clk_sync[i]  <= clk_sync[i-1];
                data_sync[i] <= data_sync[i-1];
            end
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_c = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign sdata       = data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/st7920_serial_receiver.sv
// ST7920 serial-mode receiver: frames host bits, decodes commands and
// tracks graphic-mode GDRAM addressing to produce framebuffer writes.
//   sys_clk, sys_rst_n          : block clock and async active-low reset
//   lcd_clk, lcd_data           : host serial clock (E) and data (R/W)
//   cmd_valid/rs/rw/byte        : decoded frame, pulse plus held fields
//   frame_err                   : pulse on a malformed or timed-out frame
//   gfx_mode                    : extended set and graphic display enabled
//   fb_we, fb_addr, fb_wdata    : framebuffer byte write port
module st7920_serial_receiver
    import st7920_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 lcd_clk,
    input  logic                 lcd_data,
    output logic                 cmd_valid,
    output logic                 cmd_rs,
    output logic                 cmd_rw,
    output logic [BYTE_W-1:0]    cmd_byte,
    output logic                 frame_err,
    output logic                 gfx_mode,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [BYTE_W-1:0]    fb_wdata
);

    localparam int unsigned ONES_W = $clog2(SYNC_LEN);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic sclk_rise_c;
    logic sdata;

    st7920_sclk_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sclk_edge (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .lcd_clk     (lcd_clk),
        .lcd_data    (lcd_data),
        .sclk_rise_c (sclk_rise_c),
        .sdata       (sdata)
    );

    rx_state_e          state_q, state_d;
    logic [ONES_W-1:0]  ones_q, ones_d;
    logic [1:0]         bit_q, bit_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               rw_q, rw_d;
    logic               rs_q, rs_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               ext_q, ext_d;
    logic               gfx_q, gfx_d;
    logic [3:0]         x_q, x_d;
    logic [4:0]         y_q, y_d;
    logic               bt_q, bt_d;
    logic               phase_q, phase_d;   // 0: next GDRAM address is Y, 1: X
    logic               frame_done;
    logic               abort;

    logic                 valid_d, err_d, fb_we_d;
    logic                 cmd_rs_d, cmd_rw_d;
    logic [BYTE_W-1:0]    cmd_byte_d, fb_wdata_d;
    logic [FB_ADDR_W-1:0] fb_addr_d;

    // Frame FSM, timeout and command decode.
    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        bit_d      = bit_q;
        tmo_d      = tmo_q;
        rw_d       = rw_q;
        rs_d       = rs_q;
        byte_d     = byte_q;
        ext_d      = ext_q;
        gfx_d      = gfx_q;
        x_d        = x_q;
        y_d        = y_q;
        bt_d       = bt_q;
        phase_d    = phase_q;
        frame_done = 1'b0;
        abort      = 1'b0;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        fb_we_d    = 1'b0;
        cmd_rs_d   = cmd_rs;
        cmd_rw_d   = cmd_rw;
        cmd_byte_d = cmd_byte;
        fb_addr_d  = fb_addr;
        fb_wdata_d = fb_wdata;

        // Timeout only runs mid-frame; an edge in the expiry cycle wins.
        if (state_q == ST_HUNT || sclk_rise_c) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_d = '0;
            abort = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (sclk_rise_c) begin
            case (state_q)
                ST_HUNT: begin
                    if (!sdata) begin
                        ones_d = '0;
                    end else if (ones_q == ONES_W'(SYNC_LEN - 1)) begin
                        ones_d  = '0;
                        bit_d   = '0;
                        state_d = ST_HDR;
                    end else begin
                        ones_d = ones_q + ONES_W'(1);
                    end
                end
                ST_HDR: begin
                    bit_d = bit_q + 2'd1;
                    if (bit_q == 2'd0) begin
                        rw_d = sdata;
                    end else if (bit_q == 2'd1) begin
                        rs_d = sdata;
                    end else if (sdata) begin
                        abort = 1'b1;
                    end else begin
                        bit_d   = '0;
                        state_d = ST_HI;
                    end
                end
                ST_HI, ST_LO: begin
                    byte_d = {byte_q[BYTE_W-2:0], sdata};
                    bit_d  = bit_q + 2'd1;
                    if (bit_q == 2'd3) begin
                        state_d = (state_q == ST_HI) ? ST_PADH : ST_PADL;
                    end
                end
                ST_PADH, ST_PADL: begin
                    bit_d = bit_q + 2'd1;
                    if (sdata) begin
                        abort = 1'b1;
                    end else if (bit_q == 2'd3) begin
                        if (state_q == ST_PADH) begin
                            state_d = ST_LO;
                        end else begin
                            state_d    = ST_HUNT;
                            frame_done = 1'b1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (abort) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
            ones_d  = '0;
            bit_d   = '0;
        end

        if (frame_done) begin
            valid_d    = 1'b1;
            cmd_rs_d   = rs_q;
            cmd_rw_d   = rw_q;
            cmd_byte_d = byte_q;
            if (!rw_q) begin
                if (rs_q) begin
                    // Data write: two bytes per X word, then advance X.
                    fb_we_d    = 1'b1;
                    fb_wdata_d = byte_q;
                    fb_addr_d  = {x_q[3], y_q, x_q[2:0], bt_q};
                    if (bt_q) begin
                        x_d  = x_q + 4'd1;
                        bt_d = 1'b0;
                    end else begin
                        bt_d = 1'b1;
                    end
                end else if (byte_q[7:5] == OP_FUNC_SET) begin
                    ext_d   = byte_q[2];
                    if (byte_q[2]) begin
                        gfx_d = byte_q[1];
                    end
                    phase_d = 1'b0;
                end else if (byte_q[7] == OP_GDRAM_ADDR) begin
                    // Basic-set DDRAM address: leaves GDRAM pointer alone.
                    if (ext_q) begin
                        if (!phase_q) begin
                            y_d = byte_q[4:0];
                        end else begin
                            x_d = byte_q[3:0];
                        end
                        phase_d = ~phase_q;
                        bt_d    = 1'b0;
                    end
                end else begin
                    phase_d = 1'b0;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_HUNT;
            ones_q    <= '0;
            bit_q     <= '0;
            tmo_q     <= '0;
            rw_q      <= 1'b0;
            rs_q      <= 1'b0;
            byte_q    <= '0;
            ext_q     <= 1'b0;
            gfx_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            bt_q      <= 1'b0;
            phase_q   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_rs    <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_byte  <= '0;
            frame_err <= 1'b0;
            gfx_mode  <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_wdata  <= '0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            bit_q     <= bit_d;
            tmo_q     <= tmo_d;
            rw_q      <= rw_d;
            rs_q      <= rs_d;
            byte_q    <= byte_d;
            ext_q     <= ext_d;
            gfx_q     <= gfx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bt_q      <= bt_d;
            phase_q   <= phase_d;
            cmd_valid <= valid_d;
            cmd_rs    <= cmd_rs_d;
            cmd_rw    <= cmd_rw_d;
            cmd_byte  <= cmd_byte_d;
            frame_err <= err_d;
            gfx_mode  <= ext_d & gfx_d;
            fb_we     <= fb_we_d;
            fb_addr   <= fb_addr_d;
            fb_wdata  <= fb_wdata_d;
        end
    end

endmodule
